// File: rtl/uart_depacketizer.sv
// Purpose: 8N1 UART receiver (LSB first, idle high) feeding a synchronous byte FIFO drained by rd_en.
// Latency: 2-cycle input sync; byte enters FIFO one cycle after the stop-bit sample; pop data one cycle after rd_en.
// Backpressure: none on the line; a good byte arriving at a full FIFO is dropped and flagged with overrun.
module uart_depacketizer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF         = (CLKS_PER_BIT - 1) / 2;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW           = AW + 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_PUSH,
    S_WAIT_HIGH
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [NW-1:0]   count;
  logic            wr;
  logic            rd;

  // Write only depends on full this cycle; a same-cycle pop does not make room.
  assign wr         = (state == S_PUSH) && !fifo_full;
  assign rd         = rd_en && !fifo_empty;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM: start validation at mid-bit, data/stop sampling, error and overrun pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= S_START;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rx_s) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_PUSH;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PUSH: begin
          if (fifo_full) overrun <= 1'b1;
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= shift_reg;
  end

  // FIFO pointers, occupancy and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= rd;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= mem[rd_ptr];
      end
      case ({wr, rd})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_depacketizer.sv
// Directed scenarios plus randomized frames for uart_depacketizer, checked against a queue model.
// Runs with 10 clocks per bit and a 4-entry FIFO.
module tb_uart_depacketizer;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       fifo_empty;
  logic       fifo_full;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  uart_depacketizer #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .rd_en         (rd_en),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .rx_busy       (rx_busy),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pulse counters, sampled on the falling edge.
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int vld_cnt  = 0;
  int both_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (frame_err === 1'b1)                          fe_cnt   <= fe_cnt + 1;
    if (overrun === 1'b1)                            ov_cnt   <= ov_cnt + 1;
    if (data_out_valid === 1'b1)                     vld_cnt  <= vld_cnt + 1;
    if (frame_err === 1'b1 && overrun === 1'b1)      both_cnt <= both_cnt + 1;
    if (rx_busy === 1'b1)                            busy_cnt <= busy_cnt + 1;
  end

  logic [7:0] q[$];
  bit         sending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; stop_low > 0 holds the stop bit low that many clocks first.
  task automatic send_byte(input logic [7:0] b, input int stop_low);
    sending = 1'b1;
    serial_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) tick();
    end
    if (stop_low > 0) begin
      serial_in = 1'b0;
      repeat (stop_low) tick();
    end
    serial_in = 1'b1;
    repeat (CPB) tick();
    sending = 1'b0;
  endtask

  task automatic wait_send();
    for (int i = 0; i < 400 && sending; i++) tick();
    chk("send_done", 32'(sending), 32'd0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, 32'(data_out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(data_out), 32'(exp));
    tick();
    chk({tag, "_vld_drop"}, 32'(data_out_valid), 32'd0);
  endtask

  task automatic pop_empty(input string tag, input logic [7:0] hold);
    int v0;
    v0 = vld_cnt;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    chk({tag, "_novld"}, 32'(vld_cnt - v0), 32'd0);
    chk({tag, "_hold"}, 32'(data_out), 32'(hold));
  endtask

  initial begin
    int fe0, ov0, v0, b0;
    logic [7:0] b;
    logic [7:0] last;
    bit bad_stop;
    int exp_fe, exp_ov;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_vld", 32'(data_out_valid), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_ov", 32'(overrun), 32'd0);
    repeat (5) tick();

    // Single byte with latency bound from the start edge
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_byte(8'hA5, 0);
    join_none
    for (int i = 0; i < 100 && fifo_empty; i++) tick();
    chk("single_latency", 32'(fifo_empty), 32'd0);
    wait_send();
    v0 = vld_cnt;
    pop_expect("single", 8'hA5);
    repeat (3) tick();
    chk("single_one_pulse", 32'(vld_cnt - v0), 32'd1);
    chk("single_no_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("single_no_ov", 32'(ov_cnt - ov0), 32'd0);
    chk("single_empty", 32'(fifo_empty), 32'd1);

    // Burst fill to full, then overrun
    send_byte(8'hA5, 0);
    send_byte(8'h4A, 0);
    send_byte(8'h94, 0);
    chk("burst_not_full3", 32'(fifo_full), 32'd0);
    send_byte(8'h56, 0);
    chk("burst_full", 32'(fifo_full), 32'd1);
    ov0 = ov_cnt;
    send_byte(8'h3C, 0);
    chk("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
    chk("ovr_still_full", 32'(fifo_full), 32'd1);
    pop_expect("burst0", 8'hA5);
    chk("burst_not_full_after_pop", 32'(fifo_full), 32'd0);
    pop_expect("burst1", 8'h4A);
    pop_expect("burst2", 8'h94);
    pop_expect("burst3", 8'h56);
    chk("burst_empty", 32'(fifo_empty), 32'd1);
    pop_empty("rd_empty", 8'h56);

    // Framing error with stop bit low 30 clocks
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_byte(8'h81, 30);
    join_none
    repeat (115) tick();
    chk("fe_busy_low", 32'(rx_busy), 32'd1);
    wait_send();
    chk("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_no_push", 32'(fifo_empty), 32'd1);
    chk("fe_busy_released", 32'(rx_busy), 32'd0);
    chk("fe_no_ov", 32'(ov_cnt - ov0), 32'd0);
    send_byte(8'h7E, 0);
    chk("fe_next_rx", 32'(fifo_empty), 32'd0);
    pop_expect("fe_next", 8'h7E);

    // Start glitch rejection
    fe0 = fe_cnt; b0 = busy_cnt;
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    chk("glitch_busy_seen", 32'(busy_cnt > b0), 32'd1);
    chk("glitch_busy_clear", 32'(rx_busy), 32'd0);
    chk("glitch_no_push", 32'(fifo_empty), 32'd1);
    chk("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);

    // Reset in the middle of a frame with a byte already buffered
    send_byte(8'h5A, 0);
    chk("prerst_nonempty", 32'(fifo_empty), 32'd0);
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_byte(8'hFF, 0);
    join_none
    repeat (40) tick();
    chk("prerst_busy", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_data_out", 32'(data_out), 32'd0);
    chk("mrst_vld", 32'(data_out_valid), 32'd0);
    chk("mrst_empty", 32'(fifo_empty), 32'd1);
    chk("mrst_full", 32'(fifo_full), 32'd0);
    chk("mrst_busy", 32'(rx_busy), 32'd0);
    wait_send();
    chk("mrst_after_empty", 32'(fifo_empty), 32'd1);
    chk("mrst_no_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("mrst_no_ov", 32'(ov_cnt - ov0), 32'd0);
    last = 8'h00;

    // Randomized frames against the queue model
    exp_fe = 0; exp_ov = 0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int it = 0; it < 24; it++) begin
      b = 8'($urandom);
      bad_stop = ($urandom_range(0, 4) == 0);
      send_byte(b, bad_stop ? 20 : 0);
      if (bad_stop)             exp_fe++;
      else if (q.size() < DEPTH) q.push_back(b);
      else                      exp_ov++;
      chk("rnd_fe", 32'(fe_cnt - fe0), 32'(exp_fe));
      chk("rnd_ov", 32'(ov_cnt - ov0), 32'(exp_ov));
      chk("rnd_empty", 32'(fifo_empty), 32'(q.size() == 0));
      chk("rnd_full", 32'(fifo_full), 32'(q.size() == DEPTH));
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        if (q.size() > 0) begin
          last = q.pop_front();
          pop_expect("rnd_pop", last);
        end else begin
          pop_empty("rnd_pop_empty", last);
        end
      end
    end
    while (q.size() > 0) begin
      last = q.pop_front();
      pop_expect("drain_pop", last);
    end
    chk("drain_empty", 32'(fifo_empty), 32'd1);
    chk("never_both", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
